// File: rtl/extmem_if.sv
// extmem_if: requester ports, pad pins and memory strobes of the external memory arbiter
interface extmem_if #(parameter int ADDR_W = 16, parameter int DATA_W = 8);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_done;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              ldr_req, ldr_we, ldr_gnt, ldr_done;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] rdata, pad_out, pad_oe, pad_in;
  logic              mar_we, mar_hi, ram_we;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, pad_in,
    input  cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata, pad_out, pad_oe, mar_we, mar_hi, ram_we
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, pad_in,
    output cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata, pad_out, pad_oe, mar_we, mar_hi, ram_we
  );
endinterface

// File: rtl/extmem_arbiter.sv
// extmem_arbiter: round-robin CPU/loader access to 8-bit external memory pins; EXTMEM_HI_CACHE_EN skips repeated high address bytes
module extmem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic      clk,
  input logic      rst_n,
  extmem_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ADDR_L, ADDR_H, WRITE, RWAIT, READ, DONE} state_t;
  state_t            state, state_nx, data_st;
  logic              sel, sel_nx, last_ldr, any_req, hi_hit;
  logic              we_q, we_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic [3:0]        cnt;
  assign any_req = bus.cpu_req | bus.ldr_req;
  assign data_st = we_q ? WRITE : (WAIT_CYCLES == 0 ? READ : RWAIT);
`ifdef EXTMEM_HI_CACHE_EN
  logic                     hi_valid;
  logic [ADDR_W-DATA_W-1:0] last_hi;
  assign hi_hit = hi_valid && addr_q[ADDR_W-1:DATA_W] == last_hi;
  // remember the high byte last driven onto the MAR
  always_ff @(posedge clk)
    if (!rst_n) begin
      hi_valid <= 1'b0;
      last_hi  <= '0;
    end else if (state == ADDR_H) begin
      hi_valid <= 1'b1;
      last_hi  <= addr_q[ADDR_W-1:DATA_W];
    end
`else
  assign hi_hit = 1'b0;
`endif
  // next state, arbitration pick and the request fields as they will be latched
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    addr_nx  = addr_q;
    we_nx    = we_q;
    wdata_nx = wdata_q;
    case (state)
      IDLE: if (any_req) begin
        state_nx = ADDR_L;
        sel_nx   = bus.cpu_req && bus.ldr_req ? !last_ldr : bus.ldr_req;
        addr_nx  = sel_nx ? bus.ldr_addr : bus.cpu_addr;
        we_nx    = sel_nx ? bus.ldr_we : bus.cpu_we;
        wdata_nx = sel_nx ? bus.ldr_wdata : bus.cpu_wdata;
      end
      ADDR_L:  state_nx = hi_hit ? data_st : ADDR_H;
      ADDR_H:  state_nx = data_st;
      WRITE:   state_nx = DONE;
      RWAIT:   state_nx = cnt == 4'(WAIT_CYCLES - 1) ? READ : RWAIT;
      READ:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state, latched request and pin/strobe outputs all registered from the next state
  always_ff @(posedge clk)
    if (!rst_n) begin
      state        <= IDLE;
      sel          <= 1'b0;
      last_ldr     <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      bus.pad_out  <= '0;
      bus.pad_oe   <= '0;
      bus.mar_we   <= 1'b0;
      bus.mar_hi   <= 1'b0;
      bus.ram_we   <= 1'b0;
      bus.cpu_gnt  <= 1'b0;
      bus.ldr_gnt  <= 1'b0;
      bus.cpu_done <= 1'b0;
      bus.ldr_done <= 1'b0;
      bus.rdata    <= '0;
    end else begin
      state        <= state_nx;
      sel          <= sel_nx;
      last_ldr     <= state == IDLE && any_req ? sel_nx : last_ldr;
      we_q         <= we_nx;
      addr_q       <= addr_nx;
      wdata_q      <= wdata_nx;
      cnt          <= state == RWAIT ? cnt + 4'd1 : 4'd0;
      bus.pad_out  <= state_nx == ADDR_L ? addr_nx[DATA_W-1:0] :
                      state_nx == ADDR_H ? addr_nx[ADDR_W-1:DATA_W] :
                      state_nx == WRITE  ? wdata_nx : '0;
      bus.pad_oe   <= state_nx inside {ADDR_L, ADDR_H, WRITE} ? '1 : '0;
      bus.mar_we   <= state_nx inside {ADDR_L, ADDR_H};
      bus.mar_hi   <= state_nx == ADDR_H;
      bus.ram_we   <= state_nx == WRITE;
      bus.cpu_gnt  <= !sel_nx && state_nx inside {ADDR_L, ADDR_H, WRITE, RWAIT, READ};
      bus.ldr_gnt  <= sel_nx && state_nx inside {ADDR_L, ADDR_H, WRITE, RWAIT, READ};
      bus.cpu_done <= !sel_nx && state_nx == DONE;
      bus.ldr_done <= sel_nx && state_nx == DONE;
      bus.rdata    <= state == READ ? bus.pad_in : bus.rdata;
    end
endmodule

// File: tb/tb_extmem_arbiter.sv
// tb_extmem_arbiter: directed checks of sequencing, arbitration, reset and high-byte caching
module tb_extmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  extmem_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  extmem_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [30:0] outs();
    return {bus.pad_out, bus.pad_oe, bus.mar_we, bus.mar_hi, bus.ram_we,
            bus.cpu_gnt, bus.ldr_gnt, bus.cpu_done, bus.ldr_done, bus.rdata};
  endfunction
  task automatic txn(input logic ldr, input logic we, input logic [15:0] addr,
                     output int lat, output int hi_cnt);
    bit done = 0;
    lat = 0;
    hi_cnt = 0;
    if (ldr) begin bus.ldr_req = 1; bus.ldr_we = we; bus.ldr_addr = addr; end
    else     begin bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = addr; end
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      lat++;
      if (bus.mar_we && bus.mar_hi) hi_cnt++;
      done = ldr ? bus.ldr_done : bus.cpu_done;
    end
    if (!done) chk("txn_timeout", 32'(lat), 0);
    bus.cpu_req = 0;
    bus.ldr_req = 0;
    step();
  endtask
  initial begin
    int lat1, lat2, hi1, hi2, ovl, ndone;
    logic [3:0] order;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h3456; bus.cpu_wdata = 8'h12;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = 16'h0010; bus.ldr_wdata = 8'h00;
    bus.pad_in = 8'h00;
    step();
    step();
    chk("reset_outs", 32'(outs()), 0);
    rst_n = 1;
    chk("no_gnt_at_release", 32'(bus.cpu_gnt), 0);
    step();
    chk("wr_addr_l", {bus.pad_out, bus.pad_oe, bus.mar_we, bus.mar_hi, bus.ram_we, bus.cpu_gnt},
        {8'h56, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1});
    step();
    chk("wr_addr_h", {bus.pad_out, bus.pad_oe, bus.mar_we, bus.mar_hi, bus.ram_we, bus.cpu_gnt},
        {8'h34, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1});
    step();
    chk("wr_data", {bus.pad_out, bus.pad_oe, bus.mar_we, bus.mar_hi, bus.ram_we, bus.cpu_done},
        {8'h12, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    chk("wr_done", {bus.cpu_done, bus.cpu_gnt, bus.ram_we, bus.pad_oe}, {1'b1, 1'b0, 1'b0, 8'h00});
    bus.cpu_req = 0;
    step();
    chk("wr_done_pulse", 32'(bus.cpu_done), 0);
    bus.ldr_req = 1; bus.pad_in = 8'hA5;
    step();
    chk("rd_addr_l", {bus.pad_out, bus.mar_we, bus.mar_hi, bus.ldr_gnt}, {8'h10, 1'b1, 1'b0, 1'b1});
    step();
    chk("rd_addr_h", {bus.pad_out, bus.mar_we, bus.mar_hi}, {8'h00, 1'b1, 1'b1});
    step();
    chk("rd_wait_oe", {bus.pad_oe, bus.mar_we, bus.ldr_gnt}, {8'h00, 1'b0, 1'b1});
    step();
    step();
    chk("rd_no_early_done", 32'(bus.ldr_done), 0);
    step();
    chk("rd_done", {bus.ldr_done, bus.ldr_gnt, bus.rdata}, {1'b1, 1'b0, 8'hA5});
    bus.ldr_req = 0; bus.pad_in = 8'h00;
    step();
    step();
    chk("rd_hold", 32'(bus.rdata), 32'h0A5);
    rst_n = 0;
    bus.cpu_req = 1; bus.ldr_req = 1; bus.cpu_we = 1; bus.ldr_we = 1;
    step();
    rst_n = 1;
    order = '0; ovl = 0; ndone = 0;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      step();
      if (bus.cpu_gnt && bus.ldr_gnt) ovl++;
      if (bus.cpu_done || bus.ldr_done) begin
        order[ndone] = bus.ldr_done;
        ndone++;
      end
    end
    bus.cpu_req = 0; bus.ldr_req = 0;
    step();
    chk("rr_count", 32'(ndone), 4);
    chk("rr_order", 32'(order), 32'b1010);
    chk("rr_overlap", 32'(ovl), 0);
    chk("rr_rdata_zero", 32'(bus.rdata), 0);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h4000; bus.pad_in = 8'h77;
    step();
    step();
    chk("rst_in_addr_h", {bus.mar_we, bus.mar_hi}, 2'b11);
    rst_n = 0;
    step();
    chk("rst_mid_outs", 32'(outs()), 0);
    rst_n = 1; bus.cpu_req = 0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.cpu_done) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 0);
    chk("rst_mid_rdata", 32'(bus.rdata), 0);
    bus.pad_in = 8'h3C;
    txn(1'b0, 1'b0, 16'h1200, lat1, hi1);
    bus.pad_in = 8'h5A;
    txn(1'b1, 1'b0, 16'h1201, lat2, hi2);
    chk("cache_lat1", 32'(lat1), 6);
    chk("cache_hi1", 32'(hi1), 1);
    chk("cache_rdata", 32'(bus.rdata), 32'h05A);
`ifdef EXTMEM_HI_CACHE_EN
    chk("cache_lat2", 32'(lat2), 5);
    chk("cache_hi2", 32'(hi2), 0);
`else
    chk("cache_lat2", 32'(lat2), 6);
    chk("cache_hi2", 32'(hi2), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
